// File: rtl/seg_pkg.sv
// Shared constants for the seg_scan display driver: digit codes, segment patterns, digit count.
// Patterns are active-high, bit order g..a (bit 0 = segment a).
package seg_pkg;

    localparam int NDIG = 8;

    typedef logic [3:0] code_t;
    typedef logic [6:0] pat_t;

    localparam code_t CODE_AM    = 4'hA;
    localparam code_t CODE_PM    = 4'hB;
    localparam code_t CODE_BLANK = 4'hC;
    localparam code_t CODE_DASH  = 4'hD;
    localparam code_t CODE_H     = 4'hE;

    localparam pat_t PAT_0     = 7'h3F;
    localparam pat_t PAT_1     = 7'h06;
    localparam pat_t PAT_2     = 7'h5B;
    localparam pat_t PAT_3     = 7'h4F;
    localparam pat_t PAT_4     = 7'h66;
    localparam pat_t PAT_5     = 7'h6D;
    localparam pat_t PAT_6     = 7'h7D;
    localparam pat_t PAT_7     = 7'h07;
    localparam pat_t PAT_8     = 7'h7F;
    localparam pat_t PAT_9     = 7'h6F;
    localparam pat_t PAT_A     = 7'h77;
    localparam pat_t PAT_P     = 7'h73;
    localparam pat_t PAT_BLANK = 7'h00;
    localparam pat_t PAT_DASH  = 7'h40;
    localparam pat_t PAT_H     = 7'h76;
    localparam pat_t PAT_F     = 7'h00;

endpackage

// File: rtl/seg_decode.sv
// Combinational digit-code to active-high seven-segment pattern decoder.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = PAT_F;
        case (code)
            4'h0:       pattern = PAT_0;
            4'h1:       pattern = PAT_1;
            4'h2:       pattern = PAT_2;
            4'h3:       pattern = PAT_3;
            4'h4:       pattern = PAT_4;
            4'h5:       pattern = PAT_5;
            4'h6:       pattern = PAT_6;
            4'h7:       pattern = PAT_7;
            4'h8:       pattern = PAT_8;
            4'h9:       pattern = PAT_9;
            CODE_AM:    pattern = PAT_A;
            CODE_PM:    pattern = PAT_P;
            CODE_BLANK: pattern = PAT_BLANK;
            CODE_DASH:  pattern = PAT_DASH;
            CODE_H:     pattern = PAT_H;
            default:    pattern = PAT_F;
        endcase
    end

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed 8-digit seven-segment driver with frame-coherent input latching.
// Optional digit blinking is built when SEG_BLINK_EN is defined.
module seg_scan
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 250
) (
    input  logic        CP,
    input  logic        RST,
    input  logic [31:0] DATA,
    input  logic [7:0]  DP_MASK,
    input  logic [7:0]  BLINK,
    input  logic        EN,
    output logic [7:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP,
    output logic        FRAME
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   shadow_data_q, shadow_data_d;
    logic [7:0]    shadow_dp_q, shadow_dp_d;
    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          frame_q, frame_d;

    logic          tick;
    logic          frame_tick;
    logic [3:0]    cur_code;
    logic [6:0]    cur_pat;

`ifdef SEG_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;
    logic [7:0]    shadow_blink_q, shadow_blink_d;
    logic          bwrap;
`else
    logic          unused_blink;
    assign unused_blink = ^BLINK;
`endif

    assign tick       = (pcnt_q == PW'(SCAN_DIV - 1));
    assign frame_tick = tick && (idx_q == 3'd7);
    assign cur_code   = shadow_data_q[{idx_q, 2'b00} +: 4];

    seg_decode u_decode (
        .code    (cur_code),
        .pattern (cur_pat)
    );

    always_comb begin
        pcnt_d        = tick ? '0 : pcnt_q + PW'(1);
        idx_d         = tick ? idx_q + 3'd1 : idx_q;
        shadow_data_d = frame_tick ? DATA    : shadow_data_q;
        shadow_dp_d   = frame_tick ? DP_MASK : shadow_dp_q;
        frame_d       = frame_tick;
        // Outputs follow the idx/shadow values held now, so they lag idx by one cycle.
        an_d          = EN ? ~(8'h01 << idx_q) : 8'hFF;
        seg_d         = ~cur_pat;
        dp_d          = ~shadow_dp_q[idx_q];
`ifdef SEG_BLINK_EN
        bwrap          = (bcnt_q == BW'(BLINK_DIV - 1));
        bcnt_d         = bcnt_q;
        phase_d        = phase_q;
        if (tick) begin
            bcnt_d  = bwrap ? '0 : bcnt_q + BW'(1);
            phase_d = bwrap ? ~phase_q : phase_q;
        end
        shadow_blink_d = frame_tick ? BLINK : shadow_blink_q;
        if (phase_q && shadow_blink_q[idx_q]) begin
            seg_d = 7'h7F;
            dp_d  = 1'b1;
        end
`endif
    end

    always_ff @(posedge CP) begin
        if (RST) begin
            pcnt_q         <= '0;
            idx_q          <= 3'd0;
            shadow_data_q  <= {NDIG{CODE_BLANK}};
            shadow_dp_q    <= 8'h00;
            an_q           <= 8'hFF;
            seg_q          <= 7'h7F;
            dp_q           <= 1'b1;
            frame_q        <= 1'b0;
`ifdef SEG_BLINK_EN
            bcnt_q         <= '0;
            phase_q        <= 1'b0;
            shadow_blink_q <= 8'h00;
`endif
        end else begin
            pcnt_q         <= pcnt_d;
            idx_q          <= idx_d;
            shadow_data_q  <= shadow_data_d;
            shadow_dp_q    <= shadow_dp_d;
            an_q           <= an_d;
            seg_q          <= seg_d;
            dp_q           <= dp_d;
            frame_q        <= frame_d;
`ifdef SEG_BLINK_EN
            bcnt_q         <= bcnt_d;
            phase_q        <= phase_d;
            shadow_blink_q <= shadow_blink_d;
`endif
        end
    end

    assign AN    = an_q;
    assign SEG   = seg_q;
    assign DP    = dp_q;
    assign FRAME = frame_q;

endmodule
